// File: rtl/dcache_pkg.sv
// Shared types, widths and address-field helpers for the data-cache controller.
package dcache_pkg;

  localparam int DATA_W         = 32;
  localparam int BE_W           = DATA_W / 8;
  localparam int NUM_LINES_DEF  = 8;
  localparam int LINE_WORDS_DEF = 4;
  localparam int ADDR_W_DEF     = 12;
  localparam int IDX_W          = $clog2(NUM_LINES_DEF);
  localparam int OFF_W          = $clog2(LINE_WORDS_DEF);
  localparam int TAG_W          = ADDR_W_DEF - IDX_W - OFF_W;
  localparam int CNT_W          = 3;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    REFILL
  } state_t;

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W_DEF-1:0] a);
    return a[OFF_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W_DEF-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W_DEF-1:0] a);
    return a[ADDR_W_DEF-1 -: TAG_W];
  endfunction

  function automatic logic [ADDR_W_DEF-1:0] make_addr(input logic [TAG_W-1:0] tag,
                                                      input logic [IDX_W-1:0] idx,
                                                      input logic [OFF_W-1:0] off);
    return {tag, idx, off};
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Line storage: valid/dirty/tag/data arrays with one asynchronous read port,
// one byte-enabled data write port and a metadata write that installs a line.
module dcache_store
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic              CLK,
  input  logic              clr,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              meta_we,
  input  logic              meta_dirty,
  input  logic [TAG_W-1:0]  meta_tag
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    data_q [NUM_LINES][LINE_WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];

  // Control bits: cleared by reset, otherwise updated when a line is installed or written.
  always_ff @(posedge CLK) begin
    if (clr) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= meta_dirty;
    end
  end

  // Tag array is payload and is left untouched by reset.
  always_ff @(posedge CLK) begin
    if (meta_we) begin
      tag_q[wr_idx] <= meta_tag;
    end
  end

  // Data array: byte-granular merge of the write word.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) begin
          data_q[wr_idx][wr_off][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Answers CPU requests on the Cache_* port and fills/evicts lines over D_MEM_*.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Cache_CSN,
  input  logic              Cache_WEN,
  input  logic [BE_W-1:0]   Cache_BE,
  input  logic [ADDR_W-1:0] Cache_ADDR,
  input  logic [DATA_W-1:0] Cache_DI,
  output logic [DATA_W-1:0] Cache_DOUT,
  output logic              RDY,
  output logic              VALID,
  output logic              D_MEM_CSN,
  output logic              D_MEM_WEN,
  output logic [BE_W-1:0]   D_MEM_BE,
  output logic [ADDR_W-1:0] D_MEM_ADDR,
  output logic [DATA_W-1:0] D_MEM_DOUT,
  input  logic [DATA_W-1:0] D_MEM_DI
);

  localparam logic [CNT_W-1:0] WB_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] RF_LAST = CNT_W'(LINE_WORDS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_m1;

  logic [ADDR_W-1:0]  req_addr_q;
  logic               req_wen_q;
  logic [BE_W-1:0]    req_be_q;
  logic [DATA_W-1:0]  req_di_q;
  logic [IDX_W-1:0]   req_idx;
  logic [OFF_W-1:0]   req_off;
  logic [TAG_W-1:0]   req_tag;

  logic               rd_valid, rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;
  logic [OFF_W-1:0]   rd_off;
  logic               hit;

  logic               st_wr_en;
  logic [OFF_W-1:0]   st_wr_off;
  logic [BE_W-1:0]    st_wr_be;
  logic [DATA_W-1:0]  st_wr_data;
  logic               st_meta_we;
  logic               st_meta_dirty;

  assign req_idx = addr_idx(req_addr_q);
  assign req_off = addr_off(req_addr_q);
  assign req_tag = addr_tag(req_addr_q);
  assign cnt_m1  = cnt_q - CNT_W'(1);

  // Writeback walks the victim line word by word; everything else reads the requested word.
  assign rd_off = (state_q == WRITEBACK) ? cnt_q[OFF_W-1:0] : req_off;
  assign hit    = rd_valid && (rd_tag == req_tag);

  dcache_store #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_store (
    .CLK        (CLK),
    .clr        (~RSTn),
    .rd_idx     (req_idx),
    .rd_off     (rd_off),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_en      (st_wr_en),
    .wr_idx     (req_idx),
    .wr_off     (st_wr_off),
    .wr_be      (st_wr_be),
    .wr_data    (st_wr_data),
    .meta_we    (st_meta_we),
    .meta_dirty (st_meta_dirty),
    .meta_tag   (req_tag)
  );

  // State and word counter; reset abandons any request in flight.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture: inputs are only looked at while idle.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && !Cache_CSN) begin
      req_addr_q <= Cache_ADDR;
      req_wen_q  <= Cache_WEN;
      req_be_q   <= Cache_BE;
      req_di_q   <= Cache_DI;
    end
  end

  // Next-state: counters leave their range only through a state exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!Cache_CSN) state_d = COMPARE;
      end
      COMPARE: begin
        cnt_d = '0;
        if (hit)           state_d = IDLE;
        else if (rd_dirty) state_d = WRITEBACK;
        else               state_d = REFILL;
      end
      WRITEBACK: begin
        if (cnt_q == WB_LAST) begin
          cnt_d   = '0;
          state_d = REFILL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REFILL: begin
        if (cnt_q == RF_LAST) begin
          cnt_d   = '0;
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and store writes; every output is forced to its idle value while in reset.
  always_comb begin
    RDY           = 1'b0;
    VALID         = 1'b0;
    Cache_DOUT    = '0;
    D_MEM_CSN     = 1'b1;
    D_MEM_WEN     = 1'b1;
    D_MEM_BE      = '1;
    D_MEM_ADDR    = '0;
    D_MEM_DOUT    = '0;
    st_wr_en      = 1'b0;
    st_wr_off     = req_off;
    st_wr_be      = req_be_q;
    st_wr_data    = req_di_q;
    st_meta_we    = 1'b0;
    st_meta_dirty = 1'b0;
    if (RSTn) begin
      unique case (state_q)
        IDLE: begin
          RDY = 1'b1;
        end
        COMPARE: begin
          if (hit) begin
            VALID      = 1'b1;
            Cache_DOUT = rd_data;
            if (!req_wen_q) begin
              // A zero byte-enable write still marks the line dirty.
              st_wr_en      = 1'b1;
              st_meta_we    = 1'b1;
              st_meta_dirty = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          D_MEM_CSN  = 1'b0;
          D_MEM_WEN  = 1'b0;
          D_MEM_ADDR = make_addr(rd_tag, req_idx, cnt_q[OFF_W-1:0]);
          D_MEM_DOUT = rd_data;
        end
        REFILL: begin
          if (cnt_q != RF_LAST) begin
            D_MEM_CSN  = 1'b0;
            D_MEM_ADDR = make_addr(req_tag, req_idx, cnt_q[OFF_W-1:0]);
          end
          // Memory data lags its address by one cycle, so word k-1 lands in step k.
          if (cnt_q != '0) begin
            st_wr_en   = 1'b1;
            st_wr_off  = cnt_m1[OFF_W-1:0];
            st_wr_be   = '1;
            st_wr_data = D_MEM_DI;
          end
          if (cnt_q == RF_LAST) begin
            st_meta_we    = 1'b1;
            st_meta_dirty = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a line-level cache model predicts each
// response and memory transaction; a monitor compares what the DUT presents.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        Cache_CSN = 1'b1;
  logic        Cache_WEN = 1'b1;
  logic [3:0]  Cache_BE = 4'h0;
  logic [11:0] Cache_ADDR = 12'h0;
  logic [31:0] Cache_DI = 32'h0;
  logic [31:0] Cache_DOUT;
  logic        RDY, VALID;
  logic        D_MEM_CSN, D_MEM_WEN;
  logic [3:0]  D_MEM_BE;
  logic [11:0] D_MEM_ADDR;
  logic [31:0] D_MEM_DOUT;
  logic [31:0] D_MEM_DI = 32'h0;

  dcache_ctrl dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Cache_CSN  (Cache_CSN),
    .Cache_WEN  (Cache_WEN),
    .Cache_BE   (Cache_BE),
    .Cache_ADDR (Cache_ADDR),
    .Cache_DI   (Cache_DI),
    .Cache_DOUT (Cache_DOUT),
    .RDY        (RDY),
    .VALID      (VALID),
    .D_MEM_CSN  (D_MEM_CSN),
    .D_MEM_WEN  (D_MEM_WEN),
    .D_MEM_BE   (D_MEM_BE),
    .D_MEM_ADDR (D_MEM_ADDR),
    .D_MEM_DOUT (D_MEM_DOUT),
    .D_MEM_DI   (D_MEM_DI)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          lat;
    int          acc;
    int          nmem;
    logic [11:0] addr;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
  } memop_t;

  exp_t   expq[$];
  memop_t memq[$];

  logic [31:0] tbmem  [4096];
  logic [31:0] refmem [4096];

  bit          mvalid [8];
  bit          mdirty [8];
  logic [6:0]  mtag   [8];
  logic [31:0] mdata  [8][4];

  bit chk_mem = 1'b1;
  int memops  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic stop_run(input string what);
    n_tests++;
    n_fail++;
    $display("FAIL timeout %s: DUT did not respond within bound", what);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
  endfunction

  // Cache semantics at line level: evict dirty victim, allocate, then serve the word.
  function automatic void predict(input bit wen, input logic [11:0] addr, input logic [3:0] be,
                                  input logic [31:0] di, output exp_t e);
    int idx, off;
    logic [6:0] tag;
    idx = int'(addr[4:2]);
    off = int'(addr[1:0]);
    tag = addr[11:5];
    e.nmem = 0;
    e.lat  = 1;
    e.addr = addr;
    if (!(mvalid[idx] && mtag[idx] == tag)) begin
      e.lat = 7;
      if (mvalid[idx] && mdirty[idx]) begin
        e.lat = 11;
        for (int w = 0; w < 4; w++) begin
          memop_t m;
          m.wr   = 1'b1;
          m.addr = {mtag[idx], 3'(idx), 2'(w)};
          m.data = mdata[idx][w];
          refmem[m.addr] = m.data;
          memq.push_back(m);
          e.nmem++;
        end
      end
      for (int w = 0; w < 4; w++) begin
        memop_t m;
        m.wr   = 1'b0;
        m.addr = {tag, 3'(idx), 2'(w)};
        m.data = refmem[m.addr];
        mdata[idx][w] = m.data;
        memq.push_back(m);
        e.nmem++;
      end
      mvalid[idx] = 1'b1;
      mdirty[idx] = 1'b0;
      mtag[idx]   = tag;
    end
    e.data = mdata[idx][off];
    if (!wen) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdata[idx][off][8*b +: 8] = di[8*b +: 8];
      mdirty[idx] = 1'b1;
    end
    e.is_read = wen;
  endfunction

  // Synchronous memory: read data appears one cycle after the address.
  always @(posedge CLK) begin
    if (!D_MEM_CSN) begin
      if (!D_MEM_WEN) begin
        for (int b = 0; b < 4; b++)
          if (D_MEM_BE[b]) tbmem[D_MEM_ADDR][8*b +: 8] = D_MEM_DOUT[8*b +: 8];
      end else begin
        D_MEM_DI <= tbmem[D_MEM_ADDR];
      end
    end
  end

  // Monitor: compares memory transactions and completions against the queues.
  always @(negedge CLK) begin
    if (!RSTn) begin
      memops = 0;
    end else begin
      if (!D_MEM_CSN) begin
        memops++;
        if (chk_mem) begin
          if (memq.size() == 0) begin
            check("mem_unexpected_op", {20'h0, D_MEM_ADDR}, 32'hFFFFFFFF);
          end else begin
            memop_t m;
            m = memq.pop_front();
            check($sformatf("mem_wen@%h", m.addr), {31'h0, D_MEM_WEN}, {31'h0, !m.wr});
            check($sformatf("mem_addr@%h", m.addr), {20'h0, D_MEM_ADDR}, {20'h0, m.addr});
            if (m.wr) begin
              check($sformatf("mem_wdata@%h", m.addr), D_MEM_DOUT, m.data);
              check($sformatf("mem_be@%h", m.addr), {28'h0, D_MEM_BE}, 32'hF);
            end
          end
        end
      end
      if (VALID) begin
        if (expq.size() == 0) begin
          check("unexpected_valid", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check($sformatf("latency@%h", e.addr), 32'(cyc - e.acc + 1), 32'(e.lat));
          check($sformatf("memops@%h", e.addr), 32'(memops), 32'(e.nmem));
          if (e.is_read) check($sformatf("rdata@%h", e.addr), Cache_DOUT, e.data);
        end
        memops = 0;
      end
    end
  end

  // Issue one request at posedge+1; returns at posedge+1 after the completion cycle.
  task automatic issue(input bit wen, input logic [11:0] addr, input logic [3:0] be,
                       input logic [31:0] di, input bit hold);
    exp_t e;
    int n;
    Cache_CSN  = 1'b0;
    Cache_WEN  = wen;
    Cache_ADDR = addr;
    Cache_BE   = be;
    Cache_DI   = di;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (n > 50) stop_run("rdy_wait");
    end while (!RDY);
    predict(wen, addr, be, di, e);
    e.acc = cyc + 1;
    expq.push_back(e);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (n > 50) stop_run("valid_wait");
    end while (!VALID);
    @(posedge CLK);
    #1;
    if (!hold) Cache_CSN = 1'b1;
  endtask

  initial begin
    #2000000;
    stop_run("watchdog");
  end

  initial begin
    logic [31:0] w012;
    int n, nv, nbad;
    for (int i = 0; i < 4096; i++) begin
      tbmem[i]  = $urandom;
      refmem[i] = tbmem[i];
    end
    model_reset();

    // Reset values
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_rdy", {31'h0, RDY}, 32'h0);
    check("rst_valid", {31'h0, VALID}, 32'h0);
    check("rst_dout", Cache_DOUT, 32'h0);
    check("rst_mem_csn", {31'h0, D_MEM_CSN}, 32'h1);
    check("rst_mem_wen", {31'h0, D_MEM_WEN}, 32'h1);
    check("rst_mem_be", {28'h0, D_MEM_BE}, 32'hF);
    check("rst_mem_addr", {20'h0, D_MEM_ADDR}, 32'h0);
    check("rst_mem_dout", D_MEM_DOUT, 32'h0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    @(negedge CLK);
    check("post_rst_rdy", {31'h0, RDY}, 32'h1);
    check("post_rst_valid", {31'h0, VALID}, 32'h0);
    @(posedge CLK);
    #1;

    // Directed sequence: cold miss, hits, partial write, dirty eviction
    w012 = tbmem[12'h012];
    issue(1'b1, 12'h010, 4'h0, 32'h0, 1'b0);
    issue(1'b1, 12'h011, 4'h0, 32'h0, 1'b0);
    issue(1'b0, 12'h012, 4'b0011, 32'hAABBCCDD, 1'b0);
    issue(1'b1, 12'h012, 4'h0, 32'h0, 1'b0);
    issue(1'b1, 12'h090, 4'h0, 32'h0, 1'b0);
    check("wb_merged_word", tbmem[12'h012], {w012[31:16], 16'hCCDD});

    // Reset during refill step 2 of a conflicting miss
    chk_mem    = 1'b0;
    Cache_CSN  = 1'b0;
    Cache_WEN  = 1'b1;
    Cache_ADDR = 12'h010;
    n  = 0;
    nv = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
      if (VALID) nv++;
      if (n > 40) stop_run("abort_refill_wait");
    end while (!(!D_MEM_CSN && D_MEM_WEN && D_MEM_ADDR == 12'h012));
    RSTn = 1'b0;
    @(posedge CLK);
    #1;
    RSTn      = 1'b1;
    Cache_CSN = 1'b1;
    model_reset();
    chk_mem = 1'b1;
    check("abort_no_valid", 32'(nv), 32'h0);
    issue(1'b1, 12'h090, 4'h0, 32'h0, 1'b0);

    // CSN held low across completion: back-to-back service
    issue(1'b1, 12'h091, 4'h0, 32'h0, 1'b1);
    issue(1'b1, 12'h092, 4'h0, 32'h0, 1'b0);

    // Random traffic over a small address window for frequent conflicts
    for (int t = 0; t < 250; t++) begin
      bit          wen, hold;
      logic [11:0] addr;
      wen  = 1'($urandom_range(0, 1));
      addr = 12'($urandom_range(0, 127));
      hold = (t != 249) && ($urandom_range(0, 3) == 0);
      issue(wen, addr, 4'($urandom), $urandom, hold);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge CLK);
          #1;
        end
      end
    end
    Cache_CSN = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);

    check("pending_responses", 32'(expq.size()), 32'h0);
    check("pending_memops", 32'(memq.size()), 32'h0);
    nbad = 0;
    for (int i = 0; i < 4096; i++)
      if (tbmem[i] !== refmem[i]) nbad++;
    check("mem_image_mismatches", 32'(nbad), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
